// File: rtl/pu_riscv_verilog_pkg.sv
// Shared definitions for the multiplier arbitration slice: multiply
// function encoding and the arbiter state enumeration.
package pu_riscv_verilog_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pu_riscv_rr_arbiter2.sv
// Two-way round-robin grant: a lone eligible requester wins outright,
// a tie goes to the requester named by prio. Grant is one-hot or zero.
module pu_riscv_rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       prio,
  output logic [1:0] grant
);

  // Select the winner from the eligible mask and the current priority
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/pu_riscv_mul_arbiter.sv
// Shares one non-pipelined multi-cycle multiplier between two requesters.
// Latches the granted operands, issues a single pulse, waits for the
// completion and returns the result to its owner with backpressure.
// A flushed owner still waits for mul_done since the multiplier cannot abort.
module pu_riscv_mul_arbiter
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [NREQ-1:0]        req_w,
  input  logic [NREQ*XLEN-1:0]   req_opa,
  input  logic [NREQ*XLEN-1:0]   req_opb,
  input  logic [NREQ-1:0]        flush,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [XLEN-1:0]        rsp_r,
  output logic                   mul_valid,
  output logic [1:0]             mul_op,
  output logic                   mul_w,
  output logic [XLEN-1:0]        mul_opa,
  output logic [XLEN-1:0]        mul_opb,
  input  logic                   mul_done,
  input  logic [XLEN-1:0]        mul_r,
  output logic                   busy
);

  arb_state_t      state_q, state_d;
  logic            prio_q;
  logic            killed_q;
  logic            owner_q;
  logic [1:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] opa_q, opb_q;
  logic [XLEN-1:0] rsp_r_q;

  logic [1:0]      eligible;
  logic [1:0]      grant;
  logic            take;
  logic            sel;
  logic            owner_flush;

  assign eligible    = req_valid & ~flush;
  assign sel         = grant[1];
  assign owner_flush = flush[owner_q];

  pu_riscv_rr_arbiter2 u_rr (
    .eligible (eligible),
    .prio     (prio_q),
    .grant    (grant)
  );

  // Next-state and handshake/strobe outputs for the arbitration FSM
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    mul_valid = 1'b0;
    rsp_valid = '0;
    take      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!rst && (grant != 2'b00)) begin
          req_ready = grant;
          take      = 1'b1;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mul_valid = 1'b1;
        state_d   = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A flush landing with the completion still kills the result
        if (mul_done) begin
          state_d = (killed_q || owner_flush) ? ARB_IDLE : ARB_RESP;
        end
      end
      ARB_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (owner_flush || rsp_ready[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, priority, kill flag, latched operands and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      prio_q   <= 1'b0;
      killed_q <= 1'b0;
      owner_q  <= 1'b0;
      op_q     <= 2'b00;
      w_q      <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      rsp_r_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= sel;
        prio_q  <= ~sel;
        op_q    <= sel ? req_op[3:2] : req_op[1:0];
        w_q     <= sel ? req_w[1] : req_w[0];
        opa_q   <= sel ? req_opa[2*XLEN-1:XLEN] : req_opa[XLEN-1:0];
        opb_q   <= sel ? req_opb[2*XLEN-1:XLEN] : req_opb[XLEN-1:0];
      end
      if (state_q == ARB_WAIT && mul_done) begin
        killed_q <= 1'b0;
        if (!killed_q && !owner_flush) begin
          rsp_r_q <= mul_r;
        end
      end else if ((state_q == ARB_ISSUE || state_q == ARB_WAIT) && owner_flush) begin
        killed_q <= 1'b1;
      end
    end
  end

  assign mul_op  = op_q;
  assign mul_w   = w_q;
  assign mul_opa = opa_q;
  assign mul_opb = opb_q;
  assign rsp_r   = rsp_r_q;
  assign busy    = (state_q != ARB_IDLE);

endmodule
